// File: rtl/serial_decrypter.sv
// Receive side of the YODA serial crypto link: buffers ciphertext bytes until three
// raw terminator bytes arrive, then streams p = (c - offset) ^ key to txuart.
module serial_decrypter #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter logic [7:0]  TERM_BYTE = 8'h31
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_switches,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_err,
  output logic        o_tx_stb,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_busy,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_frame_done
);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        r_state, w_state_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, r_remaining;
  logic [1:0]    r_run, r_run_stored;
  logic [7:0]    r_key, r_offset;
  logic          r_tx_stb, r_overflow, r_frame_done;
  logic [7:0]    r_tx_data;

  logic          w_accept, w_is_term, w_terminate, w_store, w_drop, w_last;
  logic [AW:0]   w_len;

  assign w_accept    = (r_state == S_FILL) && i_rx_stb && !i_rx_err;
  assign w_is_term   = (i_rx_data == TERM_BYTE);
  assign w_terminate = w_accept && w_is_term && (r_run == 2'd2);
  assign w_store     = w_accept && !w_terminate && (r_count != DEPTH_C);
  assign w_drop      = w_accept && !w_terminate && (r_count == DEPTH_C);
  // Stored run bytes are terminator material, so they are trimmed from the frame.
  assign w_len       = r_count - {{(AW-1){1'b0}}, r_run_stored};
  assign w_last      = (r_state == S_DRAIN) && r_tx_stb && !i_tx_busy && (r_remaining == ONE_C);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_FILL;
    else         r_state <= w_state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_terminate && (w_len != '0)) w_state_next = S_DRAIN;
      S_DRAIN: if (w_last) w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  // NOTE: the frame buffer has no reset; the pointers alone define which bytes are valid.
  always_ff @(posedge i_clk) begin
    if (w_store) r_mem[r_wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_remaining  <= '0;
      r_run        <= '0;
      r_run_stored <= '0;
      r_key        <= '0;
      r_offset     <= '0;
      r_tx_stb     <= 1'b0;
      r_tx_data    <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept && (r_count == '0)) r_overflow <= 1'b0;
          if (w_terminate) begin
            r_key        <= i_switches[15:8];
            r_offset     <= i_switches[7:0];
            r_run        <= '0;
            r_run_stored <= '0;
            r_rd_ptr     <= '0;
            r_remaining  <= w_len;
            if (w_len == '0) begin
              r_frame_done <= 1'b1;
              r_count      <= '0;
              r_wr_ptr     <= '0;
            end
          end else if (w_accept) begin
            if (w_is_term) begin
              r_run <= r_run + 2'd1;
              if (w_store) r_run_stored <= r_run_stored + 2'd1;
            end else begin
              r_run        <= '0;
              r_run_stored <= '0;
            end
            if (w_store) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + 1'b1;
            end
            if (w_drop) r_overflow <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!r_tx_stb) begin
            r_tx_data <= (r_mem[r_rd_ptr] - r_offset) ^ r_key;
            r_tx_stb  <= 1'b1;
          end else if (!i_tx_busy) begin
            r_tx_stb    <= 1'b0;
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_rd_ptr     <= '0;
              r_wr_ptr     <= '0;
              r_count      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_stb     = r_tx_stb;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = (r_state == S_DRAIN);
  assign o_overflow   = r_overflow;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_decrypter.sv
// Directed and randomized frames for serial_decrypter, checked against a frame-level
// model: payload bytes decrypted with the key/offset present at the terminator.
module tb_serial_decrypter;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [7:0] TERM = 8'h31;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_switches = '0;
  logic        i_rx_stb = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_err = 1'b0;
  logic        i_tx_busy = 1'b0;
  logic        o_tx_stb, o_busy, o_overflow, o_frame_done;
  logic [7:0]  o_tx_data;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_mode = 0;
  logic [7:0] tx_q[$];
  logic [7:0] payload[$];

  always #5 clk = ~clk;

  serial_decrypter #(.DEPTH(DEPTH), .AW(AW), .TERM_BYTE(TERM)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_switches(i_switches),
    .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data), .i_rx_err(i_rx_err),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_frame_done(o_frame_done)
  );

  // A byte offered while txuart is idle is taken at the following rising edge.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_tx_stb && !i_tx_busy) tx_q.push_back(o_tx_data);
      if (o_frame_done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (busy_mode)
      0:       i_tx_busy = 1'b0;
      1:       i_tx_busy = 1'b1;
      default: i_tx_busy = ($urandom_range(0, 2) == 0);
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [7:0] decrypt(input logic [7:0] c, input logic [7:0] key,
                                         input logic [7:0] off);
    logic [7:0] d;
    d = c - off;
    return d ^ key;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    i_rx_stb  = 1'b1;
    i_rx_data = b;
    i_rx_err  = e;
    tick();
    i_rx_stb  = 1'b0;
    i_rx_err  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] key, input logic [7:0] off, input bit noise,
                            input string tag);
    i_switches = {key, off};
    foreach (payload[i]) begin
      if (noise && $urandom_range(0, 3) == 0) send(8'($urandom), 1'b1);
      send(payload[i], 1'b0);
      if (i == 0) check({tag, ".ovf_clear"}, o_overflow, 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      if (noise && $urandom_range(0, 2) == 0) send(($urandom_range(0, 1) == 0) ? TERM : 8'h5c, 1'b1);
      send(TERM, 1'b0);
    end
  endtask

  // Compare drained bytes, overflow and the single done pulse against the frame model.
  task automatic finish_frame(input logic [7:0] key, input logic [7:0] off, input int base_tx,
                              input int base_done, input string tag);
    int n, m;
    logic [7:0] exp_q[$];
    n = payload.size();
    m = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < m; i++) exp_q.push_back(decrypt(payload[i], key, off));
    for (int c = 0; c < 600 && done_cnt == base_done; c++) tick();
    repeat (3) tick();
    check({tag, ".done_pulses"}, done_cnt - base_done, 1);
    check({tag, ".tx_count"}, tx_q.size() - base_tx, exp_q.size());
    foreach (exp_q[i]) begin
      check({tag, ".tx_byte"}, (base_tx + i < tx_q.size()) ? tx_q[base_tx + i] : 8'hxx, exp_q[i]);
    end
    check({tag, ".overflow"}, o_overflow, (n + 2 > DEPTH));
    check({tag, ".idle"}, o_busy, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] key, input logic [7:0] off, input bit noise,
                           input string tag);
    int base_tx, base_done;
    base_tx   = tx_q.size();
    base_done = done_cnt;
    send_frame(key, off, noise, tag);
    check({tag, ".busy"}, o_busy, (payload.size() > 0));
    i_switches = 16'($urandom);
    finish_frame(key, off, base_tx, base_done, tag);
  endtask

  initial begin
    int base_tx, base_done;
    bit stb_held, data_held;
    logic [7:0] b;

    #12;
    check("reset.tx_stb", o_tx_stb, 1'b0);
    check("reset.tx_data", o_tx_data, 8'h00);
    check("reset.busy", o_busy, 1'b0);
    check("reset.overflow", o_overflow, 1'b0);
    check("reset.frame_done", o_frame_done, 1'b0);
    tick();
    i_reset = 1'b0;
    tick();

    payload = '{8'h15, 8'h36};
    run_frame(8'h5a, 8'h03, 1'b0, "t1_basic");
    payload = '{8'h00};
    run_frame(8'h00, 8'hff, 1'b0, "t2_wrap");
    payload = '{8'h31, 8'h31, 8'h41};
    run_frame(8'h00, 8'h00, 1'b0, "t3_broken_run");
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_frame(8'h3c, 8'h11, 1'b0, "t4_overflow");
    payload = '{};
    run_frame(8'h77, 8'h22, 1'b0, "empty_frame");

    // Txuart stalled mid-drain: the offered byte must hold, and rx traffic is dropped.
    payload = '{8'h15, 8'h36};
    busy_mode = 1;
    base_tx   = tx_q.size();
    base_done = done_cnt;
    send_frame(8'h5a, 8'h03, 1'b0, "t5_stall");
    for (int c = 0; c < 20 && o_tx_stb !== 1'b1; c++) tick();
    stb_held  = 1'b1;
    data_held = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c < 4) send((c == 3) ? 8'h77 : TERM, 1'b0);
      else tick();
      if (o_tx_stb !== 1'b1) stb_held = 1'b0;
      if (o_tx_data !== decrypt(8'h15, 8'h5a, 8'h03)) data_held = 1'b0;
    end
    check("t5_stall.stb_held", stb_held, 1'b1);
    check("t5_stall.data_held", data_held, 1'b1);
    check("t5_stall.no_ovf", o_overflow, 1'b0);
    busy_mode = 0;
    finish_frame(8'h5a, 8'h03, base_tx, base_done, "t5_stall");

    // Reset lands while the second byte of a three-byte frame is on offer.
    payload = '{8'h15, 8'h36, 8'h15};
    base_tx   = tx_q.size();
    base_done = done_cnt;
    send_frame(8'h5a, 8'h03, 1'b0, "t6_abort");
    for (int c = 0; c < 40 && tx_q.size() == base_tx; c++) tick();
    tick();
    for (int c = 0; c < 20 && o_tx_stb !== 1'b1; c++) tick();
    check("t6_abort.second_offer", o_tx_stb, 1'b1);
    i_reset = 1'b1;
    #1;
    check("t6_abort.stb_drop", o_tx_stb, 1'b0);
    check("t6_abort.busy_drop", o_busy, 1'b0);
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check("t6_abort.no_done", done_cnt - base_done, 0);
    check("t6_abort.one_sent", tx_q.size() - base_tx, 1);
    check("t6_abort.tx_data_rst", o_tx_data, 8'h00);
    payload = '{8'h15};
    run_frame(8'h5a, 8'h03, 1'b0, "t6_restart");

    // Random frames with errored bytes, mid-drain switch changes and random busy.
    busy_mode = 2;
    for (int f = 0; f < 14; f++) begin
      payload = '{};
      for (int i = 0; i < $urandom_range(0, 7); i++) begin
        b = ($urandom_range(0, 3) == 0) ? TERM : 8'($urandom);
        if (b == TERM && payload.size() >= 2 &&
            payload[payload.size()-1] == TERM && payload[payload.size()-2] == TERM) b = 8'h30;
        payload.push_back(b);
      end
      if (payload.size() > 0 && payload[payload.size()-1] == TERM) payload[payload.size()-1] = 8'h42;
      run_frame(8'($urandom), 8'($urandom), 1'b1, $sformatf("rand%0d", f));
    end
    busy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
